// File: rtl/trap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// trap_ctrl_pkg
//
// Shared definitions for the trap / MRET sequencer:
//   - trap_state_t : sequencer states
//   - trap_kind_t  : kind of event latched in the detection cycle
//   - CSR addresses for the machine-mode registers the sequencer touches
//   - mcause codes (interrupt bit 31 is always 0 here)
//   - mstatus bit-update helpers for trap entry and MRET
// -----------------------------------------------------------------------------
package trap_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SAVE_EPC    = 3'd1,
    ST_SAVE_CAUSE  = 3'd2,
    ST_SAVE_TVAL   = 3'd3,
    ST_UPD_STATUS  = 3'd4,
    ST_MRET_STATUS = 3'd5,
    ST_REDIRECT    = 3'd6
  } trap_state_t;

  typedef enum logic [1:0] {
    KIND_ECALL   = 2'd0,
    KIND_EBREAK  = 2'd1,
    KIND_ILLEGAL = 2'd2,
    KIND_MRET    = 2'd3
  } trap_kind_t;

  // Machine-mode CSR addresses.
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  // Synchronous exception cause codes.
  localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;
  localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;

  // mstatus field positions.
  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  // Trap entry: stash MIE into MPIE, disable interrupts, record M as the
  // previous privilege. Every other bit passes through untouched.
  function automatic logic [31:0] mstatus_trap(input logic [31:0] status);
    logic [31:0] result;
    result = status;
    result[MSTATUS_MPIE] = status[MSTATUS_MIE];
    result[MSTATUS_MIE]  = 1'b0;
    result[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return result;
  endfunction

  // MRET: restore MIE from MPIE, set MPIE. MPP stays M because this core
  // implements machine mode only.
  function automatic logic [31:0] mstatus_mret(input logic [31:0] status);
    logic [31:0] result;
    result = status;
    result[MSTATUS_MIE]  = status[MSTATUS_MPIE];
    result[MSTATUS_MPIE] = 1'b1;
    result[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return result;
  endfunction

  // mcause value for a latched trap kind. MRET never writes mcause.
  function automatic logic [31:0] cause_of(input trap_kind_t kind);
    logic [31:0] result;
    case (kind)
      KIND_ECALL:   result = CAUSE_ECALL_M;
      KIND_EBREAK:  result = CAUSE_BREAKPOINT;
      KIND_ILLEGAL: result = CAUSE_ILLEGAL;
      default:      result = 32'd0;
    endcase
    return result;
  endfunction

endpackage : trap_ctrl_pkg

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//
// Multi-cycle trap and MRET sequencer sitting between decode/execute and the
// CSR file. When an ecall, ebreak, illegal instruction or mret is seen in EX
// it stalls the pipeline, takes over the CSR file's single write port, walks
// through the required CSR updates and finishes with a PC redirect plus flush.
// While idle, the pipeline's Zicsr write is forwarded to the CSR file as-is.
//
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   ex_valid           EX-stage instruction valid
//   ex_pc, ex_instr    PC and raw bits of the EX instruction
//   illegal_instr,
//   env_call,
//   break_point,
//   mret_instr         decoder event flags for the EX instruction
//   pipe_csr_we/
//   waddr/wdata        Zicsr write from the pipeline
//   csr_raddr          CSR file read address (0 when no read is needed)
//   csr_rdata          CSR file read data, combinational, same cycle
//   csr_we/waddr/wdata CSR file write port
//   stall              freeze IF/ID/EX (combinational, high in detection cycle)
//   flush              kill IF/ID/EX on the next edge
//   redirect_valid     load redirect_pc into the PC
//   redirect_pc        redirect target (word aligned)
//
// Trap path : IDLE -> SAVE_EPC -> SAVE_CAUSE -> SAVE_TVAL -> UPD_STATUS
//             -> REDIRECT -> IDLE
// MRET path : IDLE -> MRET_STATUS -> REDIRECT -> IDLE
// -----------------------------------------------------------------------------
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,

  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_instr,
  input  logic        illegal_instr,
  input  logic        env_call,
  input  logic        break_point,
  input  logic        mret_instr,

  input  logic        pipe_csr_we,
  input  logic [11:0] pipe_csr_waddr,
  input  logic [31:0] pipe_csr_wdata,

  output logic [11:0] csr_raddr,
  input  logic [31:0] csr_rdata,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,

  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  trap_state_t state_q, state_d;
  trap_kind_t  kind_q,  kind_d;
  logic [31:0] pc_q,    pc_d;
  logic [31:0] tval_q,  tval_d;

  logic        event_detect;
  trap_kind_t  event_kind;
  logic [31:0] event_tval;

  // ---------------------------------------------------------------------------
  // Event detection (IDLE only). ECALL outranks illegal_instr because the
  // decoder also flags ECALL as illegal; it must still resolve to cause 11.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, otherwise a path that skips the assignment infers a latch.
    event_kind = KIND_ILLEGAL;
    event_tval = ex_instr;
    if (env_call) begin
      event_kind = KIND_ECALL;
      event_tval = 32'd0;
    end else if (break_point) begin
      event_kind = KIND_EBREAK;
      event_tval = ex_pc;
    end else if (mret_instr) begin
      event_kind = KIND_MRET;
      event_tval = 32'd0;
    end
  end

  assign event_detect = (state_q == ST_IDLE) && ex_valid &&
                        (env_call || break_point || mret_instr || illegal_instr);

  // ---------------------------------------------------------------------------
  // State register and event latches
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      kind_q  <= KIND_ECALL;
      pc_q    <= 32'd0;
      tval_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      pc_q    <= pc_d;
      tval_q  <= tval_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Events arriving while busy are ignored; the pending
  // instruction is removed by the flush at the end of the sequence.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    pc_d    = pc_q;
    tval_d  = tval_q;
    case (state_q)
      ST_IDLE: begin
        if (event_detect) begin
          kind_d  = event_kind;
          pc_d    = ex_pc;
          tval_d  = event_tval;
          state_d = (event_kind == KIND_MRET) ? ST_MRET_STATUS : ST_SAVE_EPC;
        end
      end
      ST_SAVE_EPC:    state_d = ST_SAVE_CAUSE;
      ST_SAVE_CAUSE:  state_d = ST_SAVE_TVAL;
      ST_SAVE_TVAL:   state_d = ST_UPD_STATUS;
      ST_UPD_STATUS:  state_d = ST_REDIRECT;
      ST_MRET_STATUS: state_d = ST_REDIRECT;
      ST_REDIRECT:    state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    csr_raddr      = 12'd0;
    csr_we         = 1'b0;
    csr_waddr      = 12'd0;
    csr_wdata      = 32'd0;
    stall          = 1'b1;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;

    case (state_q)
      ST_IDLE: begin
        // In the detection cycle the excepting instruction's own Zicsr write
        // is dropped; otherwise the pipeline owns the write port.
        stall = event_detect;
        if (!event_detect) begin
          csr_we    = pipe_csr_we;
          csr_waddr = pipe_csr_waddr;
          csr_wdata = pipe_csr_wdata;
        end
      end
      ST_SAVE_EPC: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = {pc_q[31:2], 2'b00};
      end
      ST_SAVE_CAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = cause_of(kind_q);
      end
      ST_SAVE_TVAL: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MTVAL;
        csr_wdata = tval_q;
      end
      ST_UPD_STATUS: begin
        csr_raddr = CSR_MSTATUS;
        csr_we    = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = mstatus_trap(csr_rdata);
      end
      ST_MRET_STATUS: begin
        csr_raddr = CSR_MSTATUS;
        csr_we    = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = mstatus_mret(csr_rdata);
      end
      ST_REDIRECT: begin
        // Only direct mtvec mode exists, so the low two bits are dropped for
        // both mtvec and mepc.
        csr_raddr      = (kind_q == KIND_MRET) ? CSR_MEPC : CSR_MTVEC;
        redirect_valid = 1'b1;
        flush          = 1'b1;
        redirect_pc    = {csr_rdata[31:2], 2'b00};
      end
      default: begin
        stall = 1'b0;
      end
    endcase

    // Outputs are quiet for the whole reset interval, including the
    // pipeline pass-through path.
    if (rst) begin
      csr_raddr      = 12'd0;
      csr_we         = 1'b0;
      csr_waddr      = 12'd0;
      csr_wdata      = 32'd0;
      stall          = 1'b0;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
    end
  end

endmodule : trap_ctrl

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl
//
// Directed bench for trap_ctrl. A small behavioural CSR file answers reads
// combinationally and commits writes on the clock edge; its contents are
// loaded through the idle pass-through path. Expected values are constants
// worked out by hand from the mstatus/mcause/mtval rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_trap_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_instr;
  logic        illegal_instr;
  logic        env_call;
  logic        break_point;
  logic        mret_instr;
  logic        pipe_csr_we;
  logic [11:0] pipe_csr_waddr;
  logic [31:0] pipe_csr_wdata;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks;
  int failures;

  trap_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_instr       (ex_instr),
    .illegal_instr  (illegal_instr),
    .env_call       (env_call),
    .break_point    (break_point),
    .mret_instr     (mret_instr),
    .pipe_csr_we    (pipe_csr_we),
    .pipe_csr_waddr (pipe_csr_waddr),
    .pipe_csr_wdata (pipe_csr_wdata),
    .csr_raddr      (csr_raddr),
    .csr_rdata      (csr_rdata),
    .csr_we         (csr_we),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CSR file: only the registers the sequencer uses.
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch;

  always @(posedge clk) begin
    if (csr_we) begin
      case (csr_waddr)
        12'h300: m_mstatus  <= csr_wdata;
        12'h305: m_mtvec    <= csr_wdata;
        12'h340: m_mscratch <= csr_wdata;
        12'h341: m_mepc     <= csr_wdata;
        12'h342: m_mcause   <= csr_wdata;
        12'h343: m_mtval    <= csr_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    csr_rdata = 32'd0;
    case (csr_raddr)
      12'h300: csr_rdata = m_mstatus;
      12'h305: csr_rdata = m_mtvec;
      12'h340: csr_rdata = m_mscratch;
      12'h341: csr_rdata = m_mepc;
      12'h342: csr_rdata = m_mcause;
      12'h343: csr_rdata = m_mtval;
      default: csr_rdata = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_ex();
    ex_valid      = 1'b0;
    ex_pc         = 32'd0;
    ex_instr      = 32'd0;
    illegal_instr = 1'b0;
    env_call      = 1'b0;
    break_point   = 1'b0;
    mret_instr    = 1'b0;
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One pass-through CSR write from the pipeline, checked on the outputs.
  task automatic pipe_write(input logic [11:0] addr, input logic [31:0] data);
    pipe_csr_we    = 1'b1;
    pipe_csr_waddr = addr;
    pipe_csr_wdata = data;
    @(negedge clk);
    check("pass_we",    {31'd0, csr_we}, 32'd1);
    check("pass_waddr", {20'd0, csr_waddr}, {20'd0, addr});
    check("pass_wdata", csr_wdata, data);
    check("pass_stall", {31'd0, stall}, 32'd0);
    next_cycle();
    pipe_csr_we    = 1'b0;
    pipe_csr_waddr = 12'd0;
    pipe_csr_wdata = 32'd0;
  endtask

  // Full trap sequence. The flags must already be driven with ex_valid=1;
  // this call is at the start of detection cycle N.
  task automatic run_trap(input logic [31:0] epc, input logic [31:0] cause,
                          input logic [31:0] tval, input logic [31:0] status,
                          input logic [31:0] target);
    // N: detection
    @(negedge clk);
    check("trap_N_stall", {31'd0, stall}, 32'd1);
    check("trap_N_we",    {31'd0, csr_we}, 32'd0);
    // N+1: mepc
    next_cycle();
    @(negedge clk);
    check("trap_epc_we",    {31'd0, csr_we}, 32'd1);
    check("trap_epc_addr",  {20'd0, csr_waddr}, 32'h341);
    check("trap_epc_data",  csr_wdata, epc);
    check("trap_epc_stall", {31'd0, stall}, 32'd1);
    // N+2: mcause
    next_cycle();
    @(negedge clk);
    check("trap_cause_addr", {20'd0, csr_waddr}, 32'h342);
    check("trap_cause_data", csr_wdata, cause);
    // N+3: mtval
    next_cycle();
    @(negedge clk);
    check("trap_tval_addr", {20'd0, csr_waddr}, 32'h343);
    check("trap_tval_data", csr_wdata, tval);
    // N+4: mstatus read-modify-write
    next_cycle();
    @(negedge clk);
    check("trap_st_raddr", {20'd0, csr_raddr}, 32'h300);
    check("trap_st_addr",  {20'd0, csr_waddr}, 32'h300);
    check("trap_st_data",  csr_wdata, status);
    check("trap_st_flush", {31'd0, flush}, 32'd0);
    // N+5: redirect; flush takes the stalled instruction out of EX
    next_cycle();
    @(negedge clk);
    check("trap_rd_valid", {31'd0, redirect_valid}, 32'd1);
    check("trap_rd_flush", {31'd0, flush}, 32'd1);
    check("trap_rd_pc",    redirect_pc, target);
    check("trap_rd_we",    {31'd0, csr_we}, 32'd0);
    check("trap_rd_stall", {31'd0, stall}, 32'd1);
    // N+6: idle, flushed EX is empty
    next_cycle();
    clear_ex();
    @(negedge clk);
    check("trap_end_stall", {31'd0, stall}, 32'd0);
    check("trap_end_valid", {31'd0, redirect_valid}, 32'd0);
    check("trap_end_flush", {31'd0, flush}, 32'd0);
    next_cycle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_ex();
    // Pipeline write held active through reset: outputs must still be 0.
    pipe_csr_we    = 1'b1;
    pipe_csr_waddr = 12'h340;
    pipe_csr_wdata = 32'hDEAD_BEEF;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_rv",    {31'd0, redirect_valid}, 32'd0);
    check("rst_we",    {31'd0, csr_we}, 32'd0);
    check("rst_waddr", {20'd0, csr_waddr}, 32'd0);
    check("rst_wdata", csr_wdata, 32'd0);
    check("rst_rpc",   redirect_pc, 32'd0);
    check("rst_raddr", {20'd0, csr_raddr}, 32'd0);
    pipe_csr_we    = 1'b0;
    pipe_csr_waddr = 12'd0;
    pipe_csr_wdata = 32'd0;
    rst = 1'b0;
    next_cycle();

    // Load the CSR file through the idle pass-through path.
    pipe_write(12'h305, 32'h0000_0200);
    pipe_write(12'h300, 32'h0000_0008);
    pipe_write(12'h340, 32'h0000_00A5);

    // ECALL at 0x100 with a concurrent Zicsr write that must be suppressed.
    pipe_csr_we    = 1'b1;
    pipe_csr_waddr = 12'h340;
    pipe_csr_wdata = 32'h0000_00A5;
    ex_valid = 1'b1; ex_pc = 32'h0000_0100; ex_instr = 32'h0000_0073;
    env_call = 1'b1;
    run_trap(32'h100, 32'd11, 32'd0, 32'h0000_1880, 32'h200);
    pipe_csr_we    = 1'b0;
    pipe_csr_waddr = 12'd0;
    pipe_csr_wdata = 32'd0;

    // Illegal instruction: mstatus 0x1880 -> MPIE takes MIE=0 -> 0x1800.
    ex_valid = 1'b1; ex_pc = 32'h0000_0040; ex_instr = 32'hFFFF_FFFF;
    illegal_instr = 1'b1;
    run_trap(32'h40, 32'd2, 32'hFFFF_FFFF, 32'h0000_1800, 32'h200);

    // ECALL with illegal_instr also raised resolves to cause 11.
    ex_valid = 1'b1; ex_pc = 32'h0000_0044; ex_instr = 32'h0000_0073;
    env_call = 1'b1; illegal_instr = 1'b1;
    run_trap(32'h44, 32'd11, 32'd0, 32'h0000_1800, 32'h200);

    // EBREAK: tval is the PC.
    ex_valid = 1'b1; ex_pc = 32'h0000_0080; ex_instr = 32'h0010_0073;
    break_point = 1'b1;
    run_trap(32'h80, 32'd3, 32'h80, 32'h0000_1800, 32'h200);

    // MRET with mepc = 0x104, mstatus = 0x1880 -> 0x1888.
    pipe_write(12'h341, 32'h0000_0104);
    pipe_write(12'h300, 32'h0000_1880);
    ex_valid = 1'b1; ex_pc = 32'h0000_0300; ex_instr = 32'h3020_0073;
    mret_instr = 1'b1;
    @(negedge clk);
    check("mret_N_stall", {31'd0, stall}, 32'd1);
    check("mret_N_we",    {31'd0, csr_we}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("mret_st_stall", {31'd0, stall}, 32'd1);
    check("mret_st_we",    {31'd0, csr_we}, 32'd1);
    check("mret_st_addr",  {20'd0, csr_waddr}, 32'h300);
    check("mret_st_data",  csr_wdata, 32'h0000_1888);
    next_cycle();
    @(negedge clk);
    check("mret_rd_stall", {31'd0, stall}, 32'd1);
    check("mret_rd_raddr", {20'd0, csr_raddr}, 32'h341);
    check("mret_rd_valid", {31'd0, redirect_valid}, 32'd1);
    check("mret_rd_flush", {31'd0, flush}, 32'd1);
    check("mret_rd_pc",    redirect_pc, 32'h104);
    next_cycle();
    clear_ex();
    @(negedge clk);
    check("mret_end_stall", {31'd0, stall}, 32'd0);
    check("mret_end_valid", {31'd0, redirect_valid}, 32'd0);
    next_cycle();

    // Reset asserted in SAVE_CAUSE: outputs drop at once, no redirect later.
    ex_valid = 1'b1; ex_pc = 32'h0000_0300; ex_instr = 32'h0000_0073;
    env_call = 1'b1;
    next_cycle();               // N+1 SAVE_EPC
    next_cycle();               // N+2 SAVE_CAUSE
    @(negedge clk);
    check("mid_cause_we", {31'd0, csr_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_we",    {31'd0, csr_we}, 32'd0);
    check("mid_rst_waddr", {20'd0, csr_waddr}, 32'd0);
    check("mid_rst_wdata", csr_wdata, 32'd0);
    check("mid_rst_rv",    {31'd0, redirect_valid}, 32'd0);
    check("mid_rst_flush", {31'd0, flush}, 32'd0);
    clear_ex();
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_rv",    {31'd0, redirect_valid}, 32'd0);
      check("post_rst_stall", {31'd0, stall}, 32'd0);
      next_cycle();
    end

    // Fresh ECALL after the aborted sequence. mtvec gets a mode bit that
    // must be ignored. mstatus 0x1888 -> 0x1880.
    pipe_write(12'h305, 32'h0000_0201);
    ex_valid = 1'b1; ex_pc = 32'h0000_0104; ex_instr = 32'h0000_0073;
    env_call = 1'b1;
    run_trap(32'h104, 32'd11, 32'd0, 32'h0000_1880, 32'h200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_trap_ctrl

// File: doc/trap_ctrl.md
# trap_ctrl

Multi-cycle trap and MRET sequencer between the decode/execute stage and the CSR file. On an ecall, ebreak, illegal instruction or mret, it stalls the pipeline and takes ownership of the CSR file's single write port. It then writes mepc, mcause, mtval and mstatus in sequence, and finally issues a PC redirect with a pipeline flush. In idle it passes the pipeline's Zicsr write through to the CSR file unchanged.

## Interface
Parameters:
- RESET_VECTOR_UNUSED: none; the block has no parameters. CSR addresses and cause codes come from the shared package.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous and active-high
- ex_valid  in  1  EX-stage instruction valid
- ex_pc  in  32  PC of the EX-stage instruction
- ex_instr  in  32  raw instruction bits in EX
- illegal_instr, env_call, break_point, mret_instr  in  1 each  decoder exception flags for the EX instruction
- pipe_csr_we  in  1  Zicsr write enable from the pipeline
- pipe_csr_waddr  in  12  Zicsr write address from the pipeline
- pipe_csr_wdata  in  32  Zicsr write data from the pipeline
- csr_raddr  out  12  read address to the CSR file
- csr_rdata  in  32  combinational read data, valid in the same cycle
- csr_we  out  1  write enable to the CSR file
- csr_waddr  out  12  write address to the CSR file
- csr_wdata  out  32  write data to the CSR file
- stall  out  1  freeze IF/ID/EX
- flush  out  1  kill IF/ID/EX contents on the next edge
- redirect_valid  out  1  load redirect_pc into the PC
- redirect_pc  out  32  redirect target

## Operation
- States: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, UPD_STATUS, REDIRECT (trap path); IDLE, MRET_STATUS, REDIRECT (mret path).
- Event detection happens only in IDLE with ex_valid=1.
- Priority: env_call > break_point > mret_instr > illegal_instr. The decoder also raises illegal_instr for ECALL, so ECALL must resolve to cause 11.
- On an accepted event, latch kind, ex_pc and tval:
  - illegal: tval = ex_instr
  - ebreak: tval = ex_pc
  - ecall: tval = 0
- Cause codes (mcause bit 31 = 0): illegal = 2, breakpoint = 3, ecall-from-M = 11.
- SAVE_EPC: write mepc (0x341) = {latched_pc[31:2], 2'b00}.
- SAVE_CAUSE: write mcause (0x342).
- SAVE_TVAL: write mtval (0x343).
- UPD_STATUS (trap): read mstatus (0x300), write it back with MPIE[7] ← MIE[3], MIE[3] ← 0, MPP[12:11] ← 2'b11, all other bits unchanged.
- MRET_STATUS: read mstatus, write it back with MIE[3] ← MPIE[7], MPIE[7] ← 1, MPP[12:11] ← 2'b11 (M-only core).
- REDIRECT:
  - trap: read mtvec (0x305); redirect_pc = {mtvec[31:2], 2'b00}. Only direct mode is supported; vectored mode bits are ignored.
  - mret: read mepc (0x341); redirect_pc = {mepc[31:2], 2'b00}.
  - Assert redirect_valid=1 and flush=1, then return to IDLE.
- CSR write-port ownership:
  - IDLE with no event: csr_we/waddr/wdata = pipe_csr_*.
  - Any other cycle: the controller owns the port and pipe_csr_* is ignored.
  - An excepting instruction's own Zicsr write is suppressed: in the detection cycle csr_we is forced to 0.
- csr_raddr = 0 when no read is needed.

## Timing
- Reset (asynchronous): state = IDLE; latches cleared; stall, flush, redirect_valid, csr_we = 0; redirect_pc = 0; csr_waddr/wdata = 0.
- stall = (state != IDLE) | event_detect. It is combinational, so the pipeline freezes in detection cycle N.
- Trap path, event at N:
  - N+1 mepc write
  - N+2 mcause write
  - N+3 mtval write
  - N+4 mstatus write
  - N+5 redirect + flush
  - N+6 IDLE, stall = 0
- MRET path, event at N:
  - N+1 mstatus write
  - N+2 redirect + flush
  - N+3 IDLE
- Exactly one csr_we pulse per write state. redirect_valid and flush are single-cycle pulses.
- Events seen while busy are ignored. The stalled instruction is still presented but is removed by flush.
- In the cycle after REDIRECT the state is IDLE and a new event may be detected. The flushed EX shows ex_valid = 0, so back-to-back traps from the same instruction cannot occur.
- A reset mid-sequence returns the block to IDLE immediately. No redirect is issued; partially written CSRs keep their values.

## Structure
- Add to the common package:
  - trap_state_t enum
  - trap_kind_t (ECALL, EBREAK, ILLEGAL, MRET)
  - CSR address constants: MSTATUS, MEPC, MCAUSE, MTVAL, MTVEC
  - cause constants
  - mstatus_trap() / mstatus_mret() bit-update functions
- Single module: one always_ff for state and latches, one always_comb for outputs. No sub-module.

## Test plan
- ECALL at pc 0x0000_0100, mtvec = 0x0000_0200, mstatus = 0x0000_0008 → writes mepc = 0x100, mcause = 11, mtval = 0, mstatus = 0x0000_1880; redirect_pc = 0x200 at N+5; stall high N..N+5.
- Illegal word 0xFFFF_FFFF at pc 0x40 → mcause = 2, mtval = 0xFFFF_FFFF. ECALL with illegal_instr also high → mcause = 11, never 2.
- EBREAK at pc 0x80 → mcause = 3, mtval = 0x80.
- MRET with mepc = 0x104, mstatus = 0x0000_1880 → mstatus = 0x0000_1888; redirect_pc = 0x104 at N+2; total stall 3 cycles.
- Idle pass-through: pipe_csr_we = 1, waddr = 0x340, wdata = 0xA5 → identical on csr_*. The same write with env_call = 1 → csr_we = 0 in cycle N.
- Assert rst during SAVE_CAUSE → all outputs 0 immediately; no redirect follows. A subsequent ECALL sequences normally.
